srio_dma_split_mc: RTL

Parametrised successor to the single-mode SRIO DMA splitter. Sits between the AXI-Stream DMA read channel and the SRIO SWRITE/NWRITE packet builder. Strips a header word from the DMA stream into M_AXIS_TUSER and cuts the payload into output packets of at most pkt_size-1 words. Adds:
- configurable data and user widths
- a sticky-header mode, where one header covers a whole input frame
- unlimited-packet runs
- configuration-error detection

---
 rtl/srio_dma_split_mc.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/srio_dma_split_mc.sv
// SRIO DMA splitter: moves a header word into TUSER and cuts the payload into packets
// of at most pkt_size-1 beats. Define SRIO_DMA_SPLIT_STATS_EN for beat/header-only statistics.
module srio_dma_split_mc #(
    parameter int DATA_W = 64,
    parameter int USER_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESET,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic [USER_W-1:0] M_AXIS_TUSER,
    input  logic [31:0]       cmd,
    input  logic [CNT_W-1:0]  num_pkts,
    input  logic [CNT_W-1:0]  pkt_size,
    output logic [31:0]       status,
    output logic [USER_W-1:0] tuser_last,
    output logic [CNT_W-1:0]  pkt_cnt
`ifdef SRIO_DMA_SPLIT_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_words,
    output logic [CNT_W-1:0]  stat_hdr_only
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               srst_s;
    logic               run_r;
    logic               ent_valid_r;
    logic               ent_last_r;
    logic [DATA_W-1:0]  ent_data_r;
    logic [USER_W-1:0]  tuser_r;
    logic [CNT_W-1:0]   pkt_cnt_r;
    logic [CNT_W-1:0]   word_cnt_r;
    logic [CNT_W-1:0]   lim_r;
    logic [CNT_W-1:0]   num_r;
    logic               mode_r;
    logic [31:0]        status_r;
    logic               active_s;
    logic               m_valid_s;
    logic               m_last_s;
    logic               beat_s;
    logic               pkt_end_s;
    logic               hdr_drain_s;
    logic               drain_s;
    logic               s_ready_s;
    logic               accept_s;
    logic               start_s;
    logic [CNT_W-1:0]   pkt_cnt_inc_s;
    logic               cmd_unused_s;

    assign cmd_unused_s  = &{1'b0, cmd[31:3]};
    assign srst_s        = AXIS_ARESET | cmd[1];
    assign start_s       = (state_r == ST_IDLE) & cmd[0];
    // run_r delays enable by one cycle so a deassertion freezes the datapath on the next cycle
    assign active_s      = run_r & ((state_r == ST_HDR) | (state_r == ST_PAYLOAD));
    assign m_valid_s     = active_s & ent_valid_r & (state_r == ST_PAYLOAD);
    assign m_last_s      = m_valid_s & (ent_last_r | (word_cnt_r == lim_r));
    assign beat_s        = m_valid_s & M_AXIS_TREADY;
    assign pkt_end_s     = beat_s & m_last_s;
    assign hdr_drain_s   = active_s & ent_valid_r & (state_r == ST_HDR);
    assign drain_s       = beat_s | hdr_drain_s;
    assign accept_s      = S_AXIS_TVALID & s_ready_s;
    assign pkt_cnt_inc_s = pkt_cnt_r + CNT_W'(1);

    // Input-stage ready: empty register in IDLE, full-throughput refill while running
    always_comb begin
        s_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            s_ready_s = ~ent_valid_r;
        end else if (active_s) begin
            s_ready_s = ~ent_valid_r | drain_s;
        end else begin
            s_ready_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd[0]) begin
                    if (pkt_size < CNT_W'(2)) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        state_nxt_s = ST_HDR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (hdr_drain_s & ~ent_last_r) begin
                    state_nxt_s = ST_PAYLOAD;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (pkt_end_s) begin
                    if ((num_r != {CNT_W{1'b0}}) && (pkt_cnt_inc_s == num_r)) begin
                        state_nxt_s = ST_DONE;
                    end else if (ent_last_r | ~mode_r) begin
                        state_nxt_s = ST_HDR;
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            ST_DONE:  state_nxt_s = ST_DONE;
            ST_ERR:   state_nxt_s = ST_ERR;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State, enable pipeline and status register
    always_ff @(posedge AXIS_ACLK) begin
        if (srst_s) begin
            state_r  <= ST_IDLE;
            run_r    <= 1'b0;
            status_r <= 32'd0;
        end else begin
            state_r  <= state_nxt_s;
            run_r    <= cmd[0];
            status_r <= {29'd0,
                         (state_nxt_s == ST_HDR) | (state_nxt_s == ST_PAYLOAD),
                         (state_nxt_s == ST_ERR),
                         (state_nxt_s == ST_DONE)};
        end
    end

    // One-entry input register; a simultaneous accept and drain replaces the entry
    always_ff @(posedge AXIS_ACLK) begin
        if (srst_s) begin
            ent_valid_r <= 1'b0;
            ent_last_r  <= 1'b0;
            ent_data_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            ent_valid_r <= 1'b1;
            ent_last_r  <= S_AXIS_TLAST;
            ent_data_r  <= S_AXIS_TDATA;
        end else if (drain_s) begin
            ent_valid_r <= 1'b0;
        end else begin
            ent_valid_r <= ent_valid_r;
        end
    end

    // Configuration snapshot; the limit is formed only when pkt_size is legal
    always_ff @(posedge AXIS_ACLK) begin
        if (srst_s) begin
            lim_r  <= {CNT_W{1'b0}};
            num_r  <= {CNT_W{1'b0}};
            mode_r <= 1'b0;
        end else if (start_s && (pkt_size >= CNT_W'(2))) begin
            lim_r  <= pkt_size - CNT_W'(2);
            num_r  <= num_pkts;
            mode_r <= cmd[2];
        end else begin
            lim_r  <= lim_r;
        end
    end

    // Header capture and packet/word counters
    always_ff @(posedge AXIS_ACLK) begin
        if (srst_s) begin
            tuser_r    <= {USER_W{1'b0}};
            pkt_cnt_r  <= {CNT_W{1'b0}};
            word_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (hdr_drain_s) begin
                tuser_r <= ent_data_r[USER_W-1:0];
            end else begin
                tuser_r <= tuser_r;
            end
            if (pkt_end_s) begin
                pkt_cnt_r  <= pkt_cnt_inc_s;
                word_cnt_r <= {CNT_W{1'b0}};
            end else if (beat_s) begin
                word_cnt_r <= word_cnt_r + CNT_W'(1);
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

`ifdef SRIO_DMA_SPLIT_STATS_EN
    logic [CNT_W-1:0] stat_words_r;
    logic [CNT_W-1:0] stat_hdr_only_r;

    // Saturating statistics counters
    always_ff @(posedge AXIS_ACLK) begin
        if (srst_s) begin
            stat_words_r    <= {CNT_W{1'b0}};
            stat_hdr_only_r <= {CNT_W{1'b0}};
        end else begin
            if (beat_s && (stat_words_r != {CNT_W{1'b1}})) begin
                stat_words_r <= stat_words_r + CNT_W'(1);
            end else begin
                stat_words_r <= stat_words_r;
            end
            if (hdr_drain_s && ent_last_r && (stat_hdr_only_r != {CNT_W{1'b1}})) begin
                stat_hdr_only_r <= stat_hdr_only_r + CNT_W'(1);
            end else begin
                stat_hdr_only_r <= stat_hdr_only_r;
            end
        end
    end

    assign stat_words    = stat_words_r;
    assign stat_hdr_only = stat_hdr_only_r;
`endif

    assign S_AXIS_TREADY = s_ready_s;
    assign M_AXIS_TVALID = m_valid_s;
    assign M_AXIS_TDATA  = ent_data_r;
    assign M_AXIS_TLAST  = m_last_s;
    assign M_AXIS_TUSER  = tuser_r;
    assign status        = status_r;
    assign tuser_last    = tuser_r;
    assign pkt_cnt       = pkt_cnt_r;

endmodule
